lane_sprite_blitter: RTL and testbench
======================================

Name: lane_sprite_blitter

Overview:
- Parametrised sprite engine for the 160x120 VGA framebuffer path.
- On each start request it restores the background under the sprite's previous position, then draws the sprite in the selected lane.
- Generalised over sprite size, lane count and geometry, and adds a start/busy/done handshake.
- Sits between the game controller (lane select) and the VGA adapter's pixel-write port. Sprite and background ROMs are external, with 1-cycle synchronous read latency.

Parameters:
- SPR_W, 10, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- NUM_LANES, 3, number of lanes (2..8)
- LANE_X0, 40, x of lane 0 left edge
- LANE_PITCH, 40, x distance between adjacent lanes
- SPR_Y, 90, fixed sprite top row
- SCREEN_W, 160, background ROM row stride
- CW, 3, colour width
- TRANSP_KEY, 3'b000, colour treated as transparent (optional feature only)

Ports:
- iClock  in  1  system clock
- iResetn  in  1  asynchronous active-low reset
- iStart  in  1  request a redraw; sampled only in IDLE
- iLane  in  3  target lane index
- oBusy  out  1  high while an operation is in progress
- oDone  out  1  one-cycle pulse at completion
- oSprAddr  out  $clog2(SPR_W*SPR_H)  sprite ROM address
- iSprColour  in  CW  sprite ROM data, valid 1 cycle after address
- oBgAddr  out  17  background ROM address
- iBgColour  in  CW  background ROM data, valid 1 cycle after address
- oX  out  9  pixel x
- oY  out  8  pixel y
- oColour  out  CW  pixel colour
- oPlot  out  1  pixel write strobe

Behaviour:
- Reset (async, iResetn=0): state=IDLE, all outputs 0, stored previous-x cleared, have_prev flag=0. Applies mid-operation too; any partial frame is abandoned.
- States: IDLE -> CLEAR -> DRAW -> DONE -> IDLE.
- IDLE:
  - On iStart=1, latch lane L = min(iLane, NUM_LANES-1).
  - new_x = LANE_X0 + L*LANE_PITCH.
  - Go to CLEAR if have_prev=1, else go directly to DRAW.
- iStart outside IDLE is ignored (no queueing).
- CLEAR:
  - Counters col (0..SPR_W-1, fastest) and row (0..SPR_H-1) sweep the old rectangle at prev_x, SPR_Y.
  - oBgAddr = (SPR_Y+row)*SCREEN_W + prev_x + col, computed 17-bit unsigned.
  - Wrap col to 0 and increment row at col=SPR_W-1. After the last pixel, go to DRAW with counters reset.
- DRAW:
  - Same sweep at new_x.
  - oSprAddr = row*SPR_W + col.
- Pipeline: the address is issued in cycle t. In cycle t+1, oX/oY/oColour are registered from the delayed coordinates and the ROM data, and oPlot=1. Exactly one pixel is plotted per cycle, with no gaps between CLEAR and DRAW.
- DONE: the cycle after the final DRAW pixel is plotted:
  - oDone=1 for one cycle, oPlot=0, oBusy=0.
  - prev_x<=new_x, have_prev<=1.
  - Return to IDLE.
- oBusy: 1 from the cycle after start acceptance through the last plotted pixel.
- Latency with N=SPR_W*SPR_H:
  - First draw: oDone at cycle N+2 after start.
  - Subsequent draws: oDone at cycle 2N+2.
- Same lane as previous: CLEAR still runs (full redraw, no skip).
- oPlot=0 in IDLE and DONE. oX/oY/oColour hold their last values when oPlot=0.

Optional Feature:
- Macro BLIT_TRANSPARENCY_EN.
- Defined: in DRAW, a pixel whose iSprColour==TRANSP_KEY is emitted with oPlot=0 (its cycle is still consumed). Cycle count and oDone timing are unchanged. CLEAR pixels are unaffected.
- Undefined: every DRAW pixel is plotted, and TRANSP_KEY is unused.

Test Plan:
- Reset, then iStart with iLane=0: no CLEAR; 200 plots at x 40..49, y 90..109; the first plot has oX=40, oY=90 with colour equal to sprite word 0; oDone pulses at cycle 202.
- Then iStart with iLane=2: 200 CLEAR plots at x 40..49 using bg addr 14440.. (90*160+40), then 200 DRAW plots at x 120..129; oDone at cycle 402; oBusy is never low in between.
- iLane=5 with NUM_LANES=3: clamped to lane 2, draws at x=120.
- iStart pulses while busy are ignored: exactly one oDone is produced, and the plot count equals 400.
- iResetn dropped at DRAW pixel 50: all outputs go to 0 immediately. The next start (lane 1) skips CLEAR and draws at x=80.
- With BLIT_TRANSPARENCY_EN and sprite words 0..9 equal to 000: the first row emits no oPlot, the total plot count is 190, and oDone timing is unchanged.

Source files
------------

// File: rtl/lane_sprite_blitter.sv
// Lane sprite blitter: restores the background under the previous sprite, then draws it in the new lane.
// Optional `BLIT_TRANSPARENCY_EN suppresses the plot strobe for DRAW pixels whose colour equals TRANSP_KEY.
module lane_sprite_blitter #(
  parameter int          SPR_W      = 10,
  parameter int          SPR_H      = 20,
  parameter int          NUM_LANES  = 3,
  parameter int          LANE_X0    = 40,
  parameter int          LANE_PITCH = 40,
  parameter int          SPR_Y      = 90,
  parameter int          SCREEN_W   = 160,
  parameter int          CW         = 3,
  parameter logic [CW-1:0] TRANSP_KEY = '0,
  localparam int         SAW        = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
  input  logic           iClock,
  input  logic           iResetn,
  input  logic           iStart,
  input  logic [2:0]     iLane,
  output logic           oBusy,
  output logic           oDone,
  output logic [SAW-1:0] oSprAddr,
  input  logic [CW-1:0]  iSprColour,
  output logic [16:0]    oBgAddr,
  input  logic [CW-1:0]  iBgColour,
  output logic [8:0]     oX,
  output logic [7:0]     oY,
  output logic [CW-1:0]  oColour,
  output logic           oPlot
);
  localparam int COLW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROWW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  // DRAIN covers the cycle in which the last DRAW address is being plotted.
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAW, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [8:0]      prev_x_q, prev_x_d, new_x_q, new_x_d;
  logic            have_prev_q, have_prev_d;
  logic            pv_q, pv_d, src_q, src_d;
  logic [8:0]      px_q, px_d, x_hold_q, x_hold_d;
  logic [7:0]      py_q, py_d, y_hold_q, y_hold_d;
  logic [CW-1:0]   c_hold_q, c_hold_d;

  logic            sweeping, last_col, last_px, transp, plot;
  logic [2:0]      lane_sel;
  logic [CW-1:0]   pix_colour;

  assign sweeping = (state_q == S_CLEAR) || (state_q == S_DRAW);
  assign last_col = (col_q == COLW'(SPR_W - 1));
  assign last_px  = last_col && (row_q == ROWW'(SPR_H - 1));
  assign lane_sel = (iLane > 3'(NUM_LANES - 1)) ? 3'(NUM_LANES - 1) : iLane;
  assign pix_colour = src_q ? iSprColour : iBgColour;

`ifdef BLIT_TRANSPARENCY_EN
  assign transp = src_q && (iSprColour == TRANSP_KEY);
`else
  // Key stays referenced so both builds share one parameter list; it never masks a pixel here.
  assign transp = 1'b0 & (iSprColour == TRANSP_KEY);
`endif
  assign plot = pv_q && !transp;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = have_prev_q ? S_CLEAR : S_DRAW;
      S_CLEAR: if (last_px) state_d = S_DRAW;
      S_DRAW:  if (last_px) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d       = '0;
    row_d       = '0;
    prev_x_d    = prev_x_q;
    new_x_d     = new_x_q;
    have_prev_d = have_prev_q;
    if (sweeping) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_px ? '0 : (last_col ? row_q + 1'b1 : row_q);
    end
    if (state_q == S_IDLE && iStart)
      new_x_d = 9'(LANE_X0) + 9'(lane_sel) * 9'(LANE_PITCH);
    if (state_q == S_DONE) begin
      prev_x_d    = new_x_q;
      have_prev_d = 1'b1;
    end
    // Coordinates travel one stage so they line up with the ROM data.
    pv_d  = sweeping;
    src_d = (state_q == S_DRAW);
    px_d  = ((state_q == S_DRAW) ? new_x_q : prev_x_q) + 9'(col_q);
    py_d  = 8'(SPR_Y) + 8'(row_q);
    x_hold_d = plot ? px_q : x_hold_q;
    y_hold_d = plot ? py_q : y_hold_q;
    c_hold_d = plot ? pix_colour : c_hold_q;
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      col_q <= '0;        row_q <= '0;
      prev_x_q <= '0;     new_x_q <= '0;     have_prev_q <= 1'b0;
      pv_q <= 1'b0;       src_q <= 1'b0;
      px_q <= '0;         py_q <= '0;
      x_hold_q <= '0;     y_hold_q <= '0;    c_hold_q <= '0;
    end else begin
      col_q <= col_d;     row_q <= row_d;
      prev_x_q <= prev_x_d; new_x_q <= new_x_d; have_prev_q <= have_prev_d;
      pv_q <= pv_d;       src_q <= src_d;
      px_q <= px_d;       py_q <= py_d;
      x_hold_q <= x_hold_d; y_hold_q <= y_hold_d; c_hold_q <= c_hold_d;
    end
  end

  always_comb begin
    oBusy    = (state_q == S_CLEAR) || (state_q == S_DRAW) || (state_q == S_DRAIN);
    oDone    = (state_q == S_DONE);
    oSprAddr = '0;
    oBgAddr  = '0;
    if (state_q == S_DRAW)
      oSprAddr = SAW'(row_q) * SAW'(SPR_W) + SAW'(col_q);
    if (state_q == S_CLEAR)
      oBgAddr = (17'(SPR_Y) + 17'(row_q)) * 17'(SCREEN_W) + 17'(prev_x_q) + 17'(col_q);
    oPlot   = plot;
    oX      = plot ? px_q : x_hold_q;
    oY      = plot ? py_q : y_hold_q;
    oColour = plot ? pix_colour : c_hold_q;
  end
endmodule

// File: tb/tb_lane_sprite_blitter.sv
// Directed bench for lane_sprite_blitter: table of redraw operations plus a mid-draw reset sequence.
module tb_lane_sprite_blitter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  lane;
  logic        busy, done, plot;
  logic [7:0]  spr_addr;
  logic [2:0]  spr_col, bg_col, colour;
  logic [16:0] bg_addr;
  logic [8:0]  x;
  logic [7:0]  y;

  int tests = 0;
  int failed = 0;

  lane_sprite_blitter dut (
    .iClock(clk), .iResetn(rst_n), .iStart(start), .iLane(lane),
    .oBusy(busy), .oDone(done), .oSprAddr(spr_addr), .iSprColour(spr_col),
    .oBgAddr(bg_addr), .iBgColour(bg_col), .oX(x), .oY(y),
    .oColour(colour), .oPlot(plot)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] spr_val(int a);
    return 3'((a * 5 + 3) % 8);
  endfunction
  function automatic logic [2:0] bg_val(int a);
    return 3'((a * 3 + a / 7) % 8);
  endfunction

  // External ROMs with one cycle of read latency.
  always @(posedge clk) begin
    spr_col <= spr_val(int'(spr_addr));
    bg_col  <= bg_val(int'(bg_addr));
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] lane;
    bit         pulse;
    bit         clr;
    int         old_x;
    int         new_x;
    int         done_c;
    int         plots;
  } vec_t;

  task automatic run_op(input vec_t r, input string tag);
    int plots = 0, pix_err = 0, busy_gap = 0, done_c = -1, post_bad = 0;
    int fx = -1, fy = -1, fc = -1;
    int k, base, ex, ey, ec;
    @(negedge clk);
    start = 1'b1;
    lane  = r.lane;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 1000 && done_c < 0; c++) begin
      @(negedge clk);
      if (r.pulse && c == 5) begin start = 1'b1; lane = 3'd0; end
      if (r.pulse && c == 9) start = 1'b0;
      if (done) begin
        done_c = c;
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_plot_at_done"}, int'(plot), 0);
      end else begin
        if (!busy) busy_gap++;
        if (plot) begin
          if (r.clr && plots < 200) begin
            k = plots; base = r.old_x;
          end else begin
            k = r.clr ? plots - 200 : plots; base = r.new_x;
          end
          ex = base + k % 10;
          ey = 90 + k / 10;
          ec = (r.clr && plots < 200) ? int'(bg_val(ey * 160 + ex)) : int'(spr_val(k));
          if (plots == 0) begin fx = int'(x); fy = int'(y); fc = int'(colour); end
          if (int'(x) != ex || int'(y) != ey || int'(colour) != ec) pix_err++;
          plots++;
        end
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_c, r.done_c);
    chk({tag, "_plot_count"}, plots, r.plots);
    chk({tag, "_pixel_errors"}, pix_err, 0);
    chk({tag, "_busy_gaps"}, busy_gap, 0);
    chk({tag, "_first_x"}, fx, r.clr ? r.old_x : r.new_x);
    chk({tag, "_first_y"}, fy, 90);
    chk({tag, "_first_colour"}, fc,
        r.clr ? int'(bg_val(90 * 160 + r.old_x)) : int'(spr_val(0)));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || done || plot) post_bad++;
    end
    chk({tag, "_idle_after"}, post_bad, 0);
    $display("[TB] op %s lane=%0d done@%0d plots=%0d", tag, r.lane, done_c, plots);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_colour"}, int'(colour), 0);
    chk({tag, "_spr_addr"}, int'(spr_addr), 0);
    chk({tag, "_bg_addr"}, int'(bg_addr), 0);
  endtask

  vec_t vecs[4];
  vec_t after_rst;

  initial begin
    vecs[0] = '{lane: 3'd0, pulse: 1'b0, clr: 1'b0, old_x: 0,   new_x: 40,  done_c: 202, plots: 200};
    vecs[1] = '{lane: 3'd2, pulse: 1'b0, clr: 1'b1, old_x: 40,  new_x: 120, done_c: 402, plots: 400};
    vecs[2] = '{lane: 3'd5, pulse: 1'b0, clr: 1'b1, old_x: 120, new_x: 120, done_c: 402, plots: 400};
    vecs[3] = '{lane: 3'd1, pulse: 1'b1, clr: 1'b1, old_x: 120, new_x: 80,  done_c: 402, plots: 400};
    after_rst = '{lane: 3'd1, pulse: 1'b0, clr: 1'b0, old_x: 0, new_x: 80, done_c: 202, plots: 200};

    rst_n = 1'b0;
    start = 1'b0;
    lane  = 3'd0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    begin
      int plots = 0;
      int hit = 0;
      int bg_seen = -1;
      @(negedge clk);
      start = 1'b1;
      lane  = 3'd0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 1000 && hit == 0; c++) begin
        @(negedge clk);
        if (c == 1) bg_seen = int'(bg_addr);
        if (plot) plots++;
        if (plots == 251) hit = 1;
      end
      chk("midrst_first_bg_addr", bg_seen, 90 * 160 + 80);
      chk("midrst_reached", hit, 1);
      rst_n = 1'b0;
      #1 chk_zero("midrst");
      $display("[TB] reset dropped at draw pixel 50");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end

    run_op(after_rst, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
